coin_acceptor: RTL

- Front-end stage that sits directly upstream of the chocolate vending controller.
- Takes three raw, asynchronous coin-sensor lines (5, 10, 20 units), then synchronises, debounces and validates them.
- Drives the controller's 6-bit coin-value input with a single-cycle coded value per accepted coin; 0 at all other times.
- Rejects multi-sensor (ambiguous) events and enforces a minimum idle gap between consecutive coins.

---
 rtl/coin_acceptor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises, debounces and validates three raw coin sensors.
// Define COIN_ACCEPTOR_TALLY_EN to add saturating accepted-coin and reject counters.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_sense,
`ifdef COIN_ACCEPTOR_TALLY_EN
    input  logic       tally_clr,
    output logic [7:0] tally5,
    output logic [7:0] tally10,
    output logic [7:0] tally20,
    output logic [7:0] reject_cnt,
`endif
    output logic [5:0] coin_out,
    output logic       coin_strobe,
    output logic       reject,
    output logic       busy
);

    localparam logic [7:0] DebCnt = 8'(DEBOUNCE_CYCLES);
    localparam logic [8:0] DebLim = 9'(DEBOUNCE_CYCLES);
    localparam logic [8:0] GapLim = 9'(GAP_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StEmit,
        StReject,
        StRelease,
        StGap
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sync1_q, s_q;
    logic [2:0] pattern_q, pattern_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_inc;

    // Two-flop synchroniser; s_q is the only view of the sensors the FSM gets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b000;
            s_q     <= 3'b000;
        end else begin
            sync1_q <= coin_sense;
            s_q     <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRelease;
            pattern_q <= 3'b000;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (s_q != 3'b000) begin
                    pattern_d = s_q;
                    cnt_d     = 8'd1;
                    state_d   = StDebounce;
                end
            end
            StDebounce: begin
                if (s_q != pattern_q) begin
                    state_d = StIdle;
                end else if (cnt_q == DebCnt) begin
                    state_d = $onehot(pattern_q) ? StEmit : StReject;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            StEmit, StReject: begin
                state_d = StRelease;
                cnt_d   = 8'd0;
            end
            StRelease: begin
                // Any bounce while releasing restarts the zero count.
                if (s_q != 3'b000) begin
                    cnt_d = 8'd0;
                end else if (cnt_inc == DebLim) begin
                    state_d = StGap;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            StGap: begin
                if (cnt_inc >= GapLim) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            default: begin
                state_d = StRelease;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        coin_out    = 6'd0;
        coin_strobe = (state_q == StEmit);
        reject      = (state_q == StReject);
        busy        = (state_q != StIdle);
        if (state_q == StEmit) begin
            case (pattern_q)
                3'b001:  coin_out = 6'd5;
                3'b010:  coin_out = 6'd10;
                3'b100:  coin_out = 6'd20;
                default: coin_out = 6'd0;
            endcase
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] tally_q [4];
    logic [3:0] tally_inc;

    assign tally_inc[0] = (state_q == StEmit) && (pattern_q == 3'b001);
    assign tally_inc[1] = (state_q == StEmit) && (pattern_q == 3'b010);
    assign tally_inc[2] = (state_q == StEmit) && (pattern_q == 3'b100);
    assign tally_inc[3] = (state_q == StReject);

    // Clear has priority over a same-cycle increment; counts stick at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) tally_q[i] <= 8'd0;
        end else if (tally_clr) begin
            for (int i = 0; i < 4; i++) tally_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tally_inc[i] && (tally_q[i] != 8'hff)) tally_q[i] <= tally_q[i] + 8'd1;
            end
        end
    end

    assign tally5     = tally_q[0];
    assign tally10    = tally_q[1];
    assign tally20    = tally_q[2];
    assign reject_cnt = tally_q[3];
`endif

endmodule
